// File: rtl/riscuinho_pkg.sv
// Shared definitions for the riscuinho core: RV32I opcode constants, the 16-bit alu_op encoding
// consumed by IntegerBasicALU, the operand-A select enum and the immediate format enum.
// alu_op layout is {funct7[6:1], funct3, opcode}. funct7[0] is always 0 in legal RV32I, so it is
// dropped to fit 16 bits.
package riscuinho_pkg;

    localparam logic [6:0] TYPE_R      = 7'b0110011;
    localparam logic [6:0] TYPE_I      = 7'b0010011;
    localparam logic [6:0] TYPE_LOAD   = 7'b0000011;
    localparam logic [6:0] TYPE_STORE  = 7'b0100011;
    localparam logic [6:0] TYPE_BRANCH = 7'b1100011;
    localparam logic [6:0] TYPE_LUI    = 7'b0110111;
    localparam logic [6:0] TYPE_AUIPC  = 7'b0010111;
    localparam logic [6:0] TYPE_JAL    = 7'b1101111;
    localparam logic [6:0] TYPE_JALR   = 7'b1100111;

    localparam logic [15:0] ALU_ADD  = 16'h0033;
    localparam logic [15:0] ALU_SUB  = 16'h4033;
    localparam logic [15:0] ALU_SLL  = 16'h00B3;
    localparam logic [15:0] ALU_SLT  = 16'h0133;
    localparam logic [15:0] ALU_SLTU = 16'h01B3;
    localparam logic [15:0] ALU_XOR  = 16'h0233;
    localparam logic [15:0] ALU_SRL  = 16'h02B3;
    localparam logic [15:0] ALU_SRA  = 16'h42B3;
    localparam logic [15:0] ALU_OR   = 16'h0333;
    localparam logic [15:0] ALU_AND  = 16'h03B3;
    // Plain add in I-type form; used by LUI/AUIPC/JALR to form A + imm.
    localparam logic [15:0] ALU_ADDI = 16'h0013;

    localparam logic [15:0] ALU_LB   = 16'h0003;
    localparam logic [15:0] ALU_LH   = 16'h0083;
    localparam logic [15:0] ALU_LW   = 16'h0103;
    localparam logic [15:0] ALU_LBU  = 16'h0203;
    localparam logic [15:0] ALU_LHU  = 16'h0283;
    localparam logic [15:0] ALU_SB   = 16'h0023;
    localparam logic [15:0] ALU_SH   = 16'h00A3;
    localparam logic [15:0] ALU_SW   = 16'h0123;

    localparam logic [15:0] ALU_BEQ  = 16'h0063;
    localparam logic [15:0] ALU_BNE  = 16'h00E3;
    localparam logic [15:0] ALU_BLT  = 16'h0263;
    localparam logic [15:0] ALU_BGE  = 16'h02E3;
    localparam logic [15:0] ALU_BLTU = 16'h0363;
    localparam logic [15:0] ALU_BGEU = 16'h03E3;

    localparam logic [15:0] ALU_JAL  = 16'h006F;

    typedef enum logic [1:0] {
        OpARs1  = 2'd0,
        OpAPc   = 2'd1,
        OpAZero = 2'd2
    } op_a_sel_e;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_fmt_e;

    function automatic logic [15:0] pack_alu_op(input logic [5:0] funct7_hi,
                                                input logic [2:0] funct3,
                                                input logic [6:0] opcode);
        return {funct7_hi, funct3, opcode};
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator (combinational).
// Ports:
//   instr  in   instruction bits [31:7] (opcode bits are not needed here)
//   fmt    in   immediate format selected by the decoder
//   imm    out  immediate sign-extended from instr[31] to DATA_WIDTH; zero for ImmNone
module imm_gen
    import riscuinho_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:7]           instr,
    input  imm_fmt_e              fmt,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (fmt)
            ImmI:    imm32 = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            ImmU:    imm32 = {instr[31:12], 12'b0};
            ImmJ:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = DATA_WIDTH'($signed(imm32));
    end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: combinational decode of one instruction word into a single registered slot.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop the held slot and any incoming word (synchronous)
//   in_valid/in_ready     fetch handshake; in_ready = !out_valid | out_ready
//   instr, pc             instruction word and its address
//   out_valid/out_ready   execute handshake
//   alu_op                {funct7[6:1], funct3, opcode}
//   op_a_sel, op_b_sel    A: 0=rs1 1=pc 2=zero; B: 0=rs2 1=imm
//   rs1, rs2, rd          register indices (rs2/rd are 0 when the format has none)
//   imm                   sign-extended immediate
//   reg_we, mem_rd, mem_wr, branch, jump, illegal  control flags
//   out_pc                pc of the held instruction
// An illegal word still produces a valid slot, with every decode field zero except illegal.
module instr_decode_stage
    import riscuinho_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           alu_op,
    output logic [1:0]            op_a_sel,
    output logic                  op_b_sel,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  reg_we,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  branch,
    output logic                  jump,
    output logic                  illegal,
    output logic [DATA_WIDTH-1:0] out_pc
);

    typedef enum logic {StEmpty, StFull} state_e;
    state_e state_q;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       f7_zero, f7_alt;

    assign opc     = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign f7_zero = (f7 == 7'b0000000);
    assign f7_alt  = (f7 == 7'b0100000);

    imm_fmt_e              d_fmt;
    op_a_sel_e             d_a_sel;
    logic [15:0]           d_alu_op;
    logic                  d_b_sel, d_uses_rs2, d_writes_rd;
    logic                  d_mem_rd, d_mem_wr, d_branch, d_jump, d_illegal;
    logic [4:0]            d_rs1, d_rs2, d_rd;
    logic [DATA_WIDTH-1:0] d_imm;

    always_comb begin
        d_fmt       = ImmNone;
        d_a_sel     = OpARs1;
        d_b_sel     = 1'b0;
        d_alu_op    = '0;
        d_uses_rs2  = 1'b0;
        d_writes_rd = 1'b0;
        d_mem_rd    = 1'b0;
        d_mem_wr    = 1'b0;
        d_branch    = 1'b0;
        d_jump      = 1'b0;
        d_illegal   = 1'b0;
        case (opc)
            TYPE_R: begin
                d_alu_op    = pack_alu_op(f7[6:1], f3, opc);
                d_uses_rs2  = 1'b1;
                d_writes_rd = 1'b1;
                // The alternate funct7 only exists for SUB and SRA.
                d_illegal   = !(f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101)));
            end
            TYPE_I: begin
                d_fmt       = ImmI;
                d_b_sel     = 1'b1;
                d_writes_rd = 1'b1;
                if (f3 == 3'b001) begin
                    d_alu_op  = pack_alu_op(f7[6:1], f3, opc);
                    d_illegal = !f7_zero;
                end else if (f3 == 3'b101) begin
                    d_alu_op  = pack_alu_op(f7[6:1], f3, opc);
                    d_illegal = !(f7_zero || f7_alt);
                end else begin
                    d_alu_op  = pack_alu_op(6'b0, f3, opc);
                end
            end
            TYPE_LOAD: begin
                d_fmt       = ImmI;
                d_b_sel     = 1'b1;
                d_writes_rd = 1'b1;
                d_mem_rd    = 1'b1;
                d_alu_op    = pack_alu_op(6'b0, f3, opc);
                d_illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            TYPE_STORE: begin
                d_fmt      = ImmS;
                d_b_sel    = 1'b1;
                d_uses_rs2 = 1'b1;
                d_mem_wr   = 1'b1;
                d_alu_op   = pack_alu_op(6'b0, f3, opc);
                d_illegal  = (f3 >= 3'b011);
            end
            TYPE_BRANCH: begin
                // A/B feed the target adder; the comparison happens downstream.
                d_fmt      = ImmB;
                d_a_sel    = OpAPc;
                d_b_sel    = 1'b1;
                d_uses_rs2 = 1'b1;
                d_branch   = 1'b1;
                d_alu_op   = pack_alu_op(6'b0, f3, opc);
                d_illegal  = (f3 == 3'b010) || (f3 == 3'b011);
            end
            TYPE_LUI: begin
                d_fmt       = ImmU;
                d_a_sel     = OpAZero;
                d_b_sel     = 1'b1;
                d_writes_rd = 1'b1;
                d_alu_op    = ALU_ADDI;
            end
            TYPE_AUIPC: begin
                d_fmt       = ImmU;
                d_a_sel     = OpAPc;
                d_b_sel     = 1'b1;
                d_writes_rd = 1'b1;
                d_alu_op    = ALU_ADDI;
            end
            TYPE_JAL: begin
                d_fmt       = ImmJ;
                d_a_sel     = OpAPc;
                d_b_sel     = 1'b1;
                d_writes_rd = 1'b1;
                d_jump      = 1'b1;
                d_alu_op    = ALU_JAL;
            end
            TYPE_JALR: begin
                d_fmt       = ImmI;
                d_b_sel     = 1'b1;
                d_writes_rd = 1'b1;
                d_jump      = 1'b1;
                d_alu_op    = ALU_ADDI;
            end
            default: d_illegal = 1'b1;
        endcase

        if (d_illegal) begin
            d_fmt       = ImmNone;
            d_a_sel     = OpARs1;
            d_b_sel     = 1'b0;
            d_alu_op    = '0;
            d_uses_rs2  = 1'b0;
            d_writes_rd = 1'b0;
            d_mem_rd    = 1'b0;
            d_mem_wr    = 1'b0;
            d_branch    = 1'b0;
            d_jump      = 1'b0;
        end
    end

    assign d_rs1 = d_illegal ? 5'd0 : instr[19:15];
    assign d_rs2 = d_uses_rs2 ? instr[24:20] : 5'd0;
    assign d_rd  = d_writes_rd ? instr[11:7] : 5'd0;

    imm_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_imm_gen (
        .instr(instr[31:7]),
        .fmt  (d_fmt),
        .imm  (d_imm)
    );

    assign out_valid = (state_q == StFull);
    assign in_ready  = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            alu_op   <= '0;
            op_a_sel <= '0;
            op_b_sel <= 1'b0;
            rs1      <= '0;
            rs2      <= '0;
            rd       <= '0;
            imm      <= '0;
            reg_we   <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            branch   <= 1'b0;
            jump     <= 1'b0;
            illegal  <= 1'b0;
            out_pc   <= '0;
        end else if (flush) begin
            state_q <= StEmpty;
        end else if (in_valid && in_ready) begin
            state_q  <= StFull;
            alu_op   <= d_alu_op;
            op_a_sel <= d_a_sel;
            op_b_sel <= d_b_sel;
            rs1      <= d_rs1;
            rs2      <= d_rs2;
            rd       <= d_rd;
            imm      <= d_imm;
            reg_we   <= d_writes_rd && (d_rd != 5'd0);
            mem_rd   <= d_mem_rd;
            mem_wr   <= d_mem_wr;
            branch   <= d_branch;
            jump     <= d_jump;
            illegal  <= d_illegal;
            out_pc   <= pc;
        end else if (out_ready) begin
            state_q <= StEmpty;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

    typedef struct packed {
        logic [15:0] alu_op;
        logic [1:0]  op_a_sel;
        logic        op_b_sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [5:0]  flags; // {reg_we, mem_rd, mem_wr, branch, jump, illegal}
        logic [31:0] pc;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] alu_op;
    logic [1:0]  op_a_sel;
    logic        op_b_sel;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, out_pc;
    logic        reg_we, mem_rd, mem_wr, branch, jump, illegal;

    slot_t act;
    slot_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    assign act = {alu_op, op_a_sel, op_b_sel, rs1, rs2, rd, imm,
                  reg_we, mem_rd, mem_wr, branch, jump, illegal, out_pc};

    always #5 clk = ~clk;

    instr_decode_stage #(
        .DATA_WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .pc       (pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_op   (alu_op),
        .op_a_sel (op_a_sel),
        .op_b_sel (op_b_sel),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .imm      (imm),
        .reg_we   (reg_we),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .branch   (branch),
        .jump     (jump),
        .illegal  (illegal),
        .out_pc   (out_pc)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference decode written from the RV32I rules with integer arithmetic.
    function automatic slot_t model(input logic [31:0] w, input logic [31:0] p);
        slot_t s;
        int si, immv, aluv;
        int unsigned f7, f3, opc;
        bit ok, wr, r2;
        s = '0;
        si = w;
        f7 = w[31:25];
        f3 = w[14:12];
        opc = w[6:0];
        ok = 1; wr = 0; r2 = 0; immv = 0; aluv = 0;
        case (opc)
            'h33: begin
                ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
                aluv = (f7 >> 1) * 1024 + f3 * 128 + opc;
                r2 = 1; wr = 1;
            end
            'h13: begin
                if (f3 == 1) ok = (f7 == 0);
                else if (f3 == 5) ok = (f7 == 0) || (f7 == 'h20);
                aluv = ((f3 == 1 || f3 == 5) ? (f7 >> 1) * 1024 : 0) + f3 * 128 + opc;
                immv = si >>> 20; s.op_b_sel = 1; wr = 1;
            end
            'h03: begin
                ok = !(f3 == 3 || f3 == 6 || f3 == 7);
                aluv = f3 * 128 + opc; immv = si >>> 20;
                s.op_b_sel = 1; wr = 1; s.flags[4] = 1;
            end
            'h23: begin
                ok = (f3 < 3);
                aluv = f3 * 128 + opc;
                immv = ((si >>> 25) <<< 5) | int'(w[11:7]);
                s.op_b_sel = 1; r2 = 1; s.flags[3] = 1;
            end
            'h63: begin
                ok = !(f3 == 2 || f3 == 3);
                aluv = f3 * 128 + opc;
                immv = ((si >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5)
                     | (int'(w[11:8]) << 1);
                s.op_a_sel = 1; s.op_b_sel = 1; r2 = 1; s.flags[2] = 1;
            end
            'h37, 'h17: begin
                aluv = 'h13; immv = w & 'hFFFFF000;
                s.op_a_sel = (opc == 'h37) ? 2 : 1; s.op_b_sel = 1; wr = 1;
            end
            'h6F: begin
                aluv = 'h6F;
                immv = ((si >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11)
                     | (int'(w[30:21]) << 1);
                s.op_a_sel = 1; s.op_b_sel = 1; wr = 1; s.flags[1] = 1;
            end
            'h67: begin
                aluv = 'h13; immv = si >>> 20;
                s.op_b_sel = 1; wr = 1; s.flags[1] = 1;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            s = '0;
            s.flags[0] = 1;
            s.pc = p;
            return s;
        end
        s.alu_op = aluv[15:0];
        s.rs1 = w[19:15];
        s.rs2 = r2 ? w[24:20] : 5'd0;
        s.rd = wr ? w[11:7] : 5'd0;
        s.flags[5] = wr && (w[11:7] != 0);
        s.imm = immv;
        s.pc = p;
        return s;
    endfunction

    function automatic slot_t mk(input logic [15:0] a, input logic [1:0] asel, input logic bsel,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                 input logic [31:0] iv, input logic [5:0] fl);
        slot_t s;
        s = '{alu_op: a, op_a_sel: asel, op_b_sel: bsel, rs1: r1, rs2: r2, rd: d, imm: iv,
              flags: fl, pc: 32'd0};
        return s;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) w[6:0] = opcs[k];
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    // One cycle of stimulus; the expected slot is queued when the word is accepted.
    task automatic drive(input logic iv, input logic [31:0] w, input logic ordy, input logic fl,
                         input bit use_hand, input slot_t hand);
        slot_t e;
        logic [31:0] p;
        bit accept;
        @(negedge clk);
        p = pc_ctr;
        pc_ctr += 4;
        in_valid = iv; instr = w; pc = p; out_ready = ordy; flush = fl;
        #2;
        // The monitor has already popped a consumed slot, so an empty queue means a free slot.
        accept = iv && (ordy || sb.size() == 0) && !fl;
        if (fl) sb.delete();
        else if (accept) begin
            e = use_hand ? hand : model(w, p);
            e.pc = p;
            sb.push_back(e);
        end
    endtask

    // Monitor: compares the presented slot against the scoreboard head every cycle it is valid.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check("out_valid", 128'(out_valid), 128'(sb.size() != 0));
            check("in_ready", 128'(in_ready), 128'(sb.size() == 0 || out_ready));
            if (out_valid && sb.size() != 0) begin
                check("slot", 128'(act), 128'(sb[0]));
                if (out_ready && !flush) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] dir_w [8];
        slot_t       dir_e [8];
        slot_t       none;
        none = '0;

        dir_w[0] = 32'h00500093; dir_e[0] = mk(16'h0013, 0, 1, 0, 0, 1, 32'd5, 6'b100000);
        dir_w[1] = 32'h402081B3; dir_e[1] = mk(16'h4033, 0, 0, 1, 2, 3, 32'd0, 6'b100000);
        dir_w[2] = 32'h4032D293; dir_e[2] = mk(16'h4293, 0, 1, 5, 0, 5, 32'h403, 6'b100000);
        dir_w[3] = 32'h12345137; dir_e[3] = mk(16'h0013, 2, 1, 8, 0, 2, 32'h12345000, 6'b100000);
        dir_w[4] = 32'hFF9FF0EF; dir_e[4] = mk(16'h006F, 1, 1, 31, 0, 1, 32'hFFFFFFF8, 6'b100010);
        dir_w[5] = 32'h0020A223; dir_e[5] = mk(16'h0123, 0, 1, 1, 2, 0, 32'd4, 6'b001000);
        dir_w[6] = 32'hFFFFFFFF; dir_e[6] = mk(16'h0000, 0, 0, 0, 0, 0, 32'd0, 6'b000001);
        dir_w[7] = 32'h0020B023; dir_e[7] = mk(16'h0000, 0, 0, 0, 0, 0, 32'd0, 6'b000001);

        #1 rst_n = 1'b0;
        #3;
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_slot", 128'(act), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed words with hand-derived expectations.
        for (int i = 0; i < 8; i++) drive(1, dir_w[i], 1, 0, 1, dir_e[i]);
        drive(0, 0, 1, 0, 0, none);

        // Back-pressure: slot held for 3 cycles, then back-to-back acceptance.
        drive(1, dir_w[0], 0, 0, 1, dir_e[0]);
        for (int i = 0; i < 3; i++) begin
            drive(1, rand_word(), 0, 0, 0, none);
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        for (int i = 0; i < 6; i++) drive(1, rand_word(), 1, 0, 0, none);
        drive(0, 0, 1, 0, 0, none);

        // Flush while full with a word offered.
        drive(1, dir_w[1], 0, 0, 0, none);
        drive(1, dir_w[2], 0, 1, 0, none);
        drive(0, 0, 0, 0, 0, none);
        drive(1, dir_w[3], 1, 1, 0, none);
        drive(0, 0, 1, 0, 0, none);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, 0, none);

        // Asynchronous reset while a slot is held.
        drive(1, dir_w[4], 0, 0, 0, none);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_rst_out_valid", 128'(out_valid), 128'(0));
        check("async_rst_slot", 128'(act), 128'(0));
        sb.delete();
        drive(0, 0, 1, 0, 0, none);
        drive(0, 0, 1, 0, 0, none);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) drive(1, rand_word(), $urandom_range(0, 1) == 1, 0, 0, none);

        // Drain and confirm nothing was left behind.
        repeat (4) drive(0, 0, 1, 0, 0, none);
        check("drained", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
